// File: rtl/dkongjr_audio_mixer_if.sv
// rtl/dkongjr_audio_mixer_if.sv - channel sample/gain bus and mixed-sample result bus for the audio mixer
// Optional clip flag is present only when MIXER_CLIP_DETECT_EN is defined.
interface dkongjr_audio_mixer_if #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 16,
    parameter int GAIN_WIDTH = 9
);
    logic [NUM_CH*DATA_WIDTH-1:0] ch_in;
    logic [NUM_CH*GAIN_WIDTH-1:0] ch_gain;
    logic                         mute;
    logic signed [DATA_WIDTH-1:0] out;
    logic                         out_valid;
    logic                         busy;
`ifdef MIXER_CLIP_DETECT_EN
    logic                         clip;

    modport master (output ch_in, ch_gain, mute, input out, out_valid, busy, clip);
    modport slave  (input ch_in, ch_gain, mute, output out, out_valid, busy, clip);
`else
    modport master (output ch_in, ch_gain, mute, input out, out_valid, busy);
    modport slave  (input ch_in, ch_gain, mute, output out, out_valid, busy);
`endif
endinterface

// File: rtl/dkongjr_audio_mixer.sv
// rtl/dkongjr_audio_mixer.sv - time-multiplexed per-channel gain mixer with saturation (optional MIXER_CLIP_DETECT_EN)
module dkongjr_audio_mixer #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 16,
    parameter int GAIN_WIDTH = 9,
    parameter int GAIN_SCALE = 8,
    parameter int COUNT_BITS = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [COUNT_BITS-1:0] div,
    dkongjr_audio_mixer_if.slave  bus
);
    localparam int IW = $clog2(NUM_CH);
    localparam int AW = DATA_WIDTH + GAIN_WIDTH + $clog2(NUM_CH) + 1;
    localparam logic signed [AW-1:0] SMAX = AW'(2**(DATA_WIDTH-1) - 1);
    localparam logic signed [AW-1:0] SMIN = ~SMAX;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CH - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, SAT} state_t;

    state_t                       state, state_nxt;
    logic [COUNT_BITS-1:0]        count;
    logic [COUNT_BITS-1:0]        div_m1;
    logic                         tick;
    logic signed [AW-1:0]         acc, acc_nxt;
    logic [IW-1:0]                idx, idx_nxt;
    logic signed [DATA_WIDTH-1:0] out_q, out_nxt;
    logic                         valid_q, valid_nxt;
    logic                         load;

    logic signed [DATA_WIDTH-1:0] snap_in   [NUM_CH];
    logic [GAIN_WIDTH-1:0]        snap_gain [NUM_CH];

    logic signed [AW-1:0]         mul_a, mul_b, prod;
    logic signed [AW-1:0]         r;
    logic                         sat_hi, sat_lo;
    logic signed [DATA_WIDTH-1:0] clamped;

    // div=0 wraps div-1 to all ones, giving the full 2^COUNT_BITS period
    assign div_m1 = div - COUNT_BITS'(1);
    assign tick   = (count == div_m1);

    // Free-running sample-tick divider; keeps counting even while a mix is in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + COUNT_BITS'(1);
        end
    end

    // Shadow copy of all inputs taken on the accepted tick so the source may change afterwards
    always_ff @(posedge clk) begin
        if (load) begin
            for (int k = 0; k < NUM_CH; k++) begin
                snap_in[k]   <= bus.ch_in[k*DATA_WIDTH +: DATA_WIDTH];
                snap_gain[k] <= bus.ch_gain[k*GAIN_WIDTH +: GAIN_WIDTH];
            end
        end
    end

    // Shared multiplier operands, widened to the accumulator so the product never overflows
    always_comb begin
        mul_a = {{(AW-DATA_WIDTH){snap_in[idx][DATA_WIDTH-1]}}, snap_in[idx]};
        mul_b = {{(AW-GAIN_WIDTH){1'b0}}, snap_gain[idx]};
        prod  = mul_a * mul_b;
    end

    // Rescale by the gain fraction (floor) and clamp to the output sample range
    always_comb begin
        r       = acc >>> GAIN_SCALE;
        sat_hi  = (r > SMAX);
        sat_lo  = (r < SMIN);
        clamped = sat_hi ? {1'b0, {(DATA_WIDTH-1){1'b1}}} :
                  sat_lo ? {1'b1, {(DATA_WIDTH-1){1'b0}}} :
                  r[DATA_WIDTH-1:0];
    end

`ifdef MIXER_CLIP_DETECT_EN
    logic clip_q, clip_nxt;
    assign bus.clip = clip_q;
`endif

    // Next-state and datapath updates; a tick seen outside IDLE is simply ignored
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        idx_nxt   = idx;
        out_nxt   = out_q;
        valid_nxt = 1'b0;
        load      = 1'b0;
`ifdef MIXER_CLIP_DETECT_EN
        clip_nxt  = clip_q;
`endif
        case (state)
            IDLE: begin
                if (tick) begin
                    load      = 1'b1;
                    acc_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                acc_nxt = acc + prod;
                idx_nxt = idx + IW'(1);
                if (idx == LAST_IDX) begin
                    idx_nxt   = '0;
                    state_nxt = SAT;
                end
            end
            SAT: begin
                out_nxt   = bus.mute ? '0 : clamped;
                valid_nxt = 1'b1;
`ifdef MIXER_CLIP_DETECT_EN
                clip_nxt  = clip_q | sat_hi | sat_lo;
`endif
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any partial mix
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            acc     <= '0;
            idx     <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
`ifdef MIXER_CLIP_DETECT_EN
            clip_q  <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            acc     <= acc_nxt;
            idx     <= idx_nxt;
            out_q   <= out_nxt;
            valid_q <= valid_nxt;
`ifdef MIXER_CLIP_DETECT_EN
            clip_q  <= clip_nxt;
`endif
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = valid_q;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_dkongjr_audio_mixer.sv
// tb/tb_dkongjr_audio_mixer.sv - directed self-checking bench for dkongjr_audio_mixer
module tb_dkongjr_audio_mixer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] div = 10'd8;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         n;

    dkongjr_audio_mixer_if #(.NUM_CH(4), .DATA_WIDTH(16), .GAIN_WIDTH(9)) bus ();

    dkongjr_audio_mixer #(
        .NUM_CH(4), .DATA_WIDTH(16), .GAIN_WIDTH(9), .GAIN_SCALE(8), .COUNT_BITS(10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .div   (div),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int k, input int v, input int g);
        bus.ch_in[k*16 +: 16] = 16'(v);
        bus.ch_gain[k*9 +: 9] = 9'(g);
    endtask

    task automatic set_all(input int v, input int g);
        for (int k = 0; k < 4; k++) set_ch(k, v, g);
    endtask

    // Counts edges until out_valid is seen, bounded
    task automatic wait_valid(output int cnt);
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (!bus.out_valid && cnt < 40);
        if (!bus.out_valid) chk("valid_timeout", int'(bus.out_valid), 1);
    endtask

    initial begin
        bus.mute = 1'b0;
        set_all(1000, 256);

        // Reset state
        step(2);
        chk("rst_out", bus.out, 0);
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_busy", int'(bus.busy), 0);
`ifdef MIXER_CLIP_DETECT_EN
        chk("rst_clip", int'(bus.clip), 0);
`endif
        reset = 1'b0;

        // 1: unity gains, latency and cadence
        wait_valid(n);
        chk("t1_first_latency", n, 13);
        chk("t1_out", bus.out, 4000);
        chk("t1_busy_at_valid", int'(bus.busy), 0);
        step(1);
        chk("t1_valid_width", int'(bus.out_valid), 0);
        chk("t1_hold", bus.out, 4000);
        wait_valid(n);
        chk("t1_period", n + 1, 8);
        chk("t1_out2", bus.out, 4000);

        // 2: positive saturation
        set_all(0, 0);
        set_ch(0, 30000, 256);
        set_ch(1, 30000, 256);
        wait_valid(n);
        chk("t2_pos_sat", bus.out, 32767);
`ifdef MIXER_CLIP_DETECT_EN
        chk("t2_clip", int'(bus.clip), 1);
`endif

        // 3: negative saturation and floor rounding
        set_ch(0, -20000, 256);
        set_ch(1, -20000, 256);
        wait_valid(n);
        chk("t3_neg_sat", bus.out, -32768);
        set_all(0, 0);
        set_ch(0, -3, 128);
        wait_valid(n);
        chk("t3_floor", bus.out, -2);
`ifdef MIXER_CLIP_DETECT_EN
        chk("t3_clip_sticky", int'(bus.clip), 1);
`endif
        set_all(5000, 0);
        set_ch(0, 100, 511);
        wait_valid(n);
        chk("t3_max_gain_zero_gain", bus.out, 199);
        set_all(-32768, 511);
        wait_valid(n);
        chk("t3_wide_acc_sat", bus.out, -32768);

        // 4: inputs changed after the tick do not affect the current mix
        set_all(1000, 256);
        step(3);
        chk("t4_busy_after_tick", int'(bus.busy), 1);
        set_all(2000, 256);
        wait_valid(n);
        chk("t4_latency", n, 5);
        chk("t4_snap_old", bus.out, 4000);
        wait_valid(n);
        chk("t4_snap_new", bus.out, 8000);

        // 5: mute
        set_all(1000, 256);
        bus.mute = 1'b1;
        wait_valid(n);
        chk("t5_mute_valid", int'(bus.out_valid), 1);
        chk("t5_mute_out", bus.out, 0);
        step(1);
        bus.mute = 1'b0;
        wait_valid(n);
        chk("t5_unmute_out", bus.out, 4000);

        // 6: reset in the middle of ACCUM
        bus.ch_in[15:0] = 16'd3000;
        step(4);
        chk("t6_busy_before", int'(bus.busy), 1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("t6_out", bus.out, 0);
        chk("t6_valid", int'(bus.out_valid), 0);
        chk("t6_busy", int'(bus.busy), 0);
`ifdef MIXER_CLIP_DETECT_EN
        chk("t6_clip_cleared", int'(bus.clip), 0);
`endif
        wait_valid(n);
        chk("t6_latency", n, 13);
        chk("t6_out_after", bus.out, 6000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
